div_issue: RTL
==============

DIV_ISSUE -- requirements
Module: div_issue

Interface
REQ-001 SHALL expose parameter XLEN, default 64, datapath width.
REQ-002 SHALL expose parameter DIV_ABORT_EN, default 1; when 1, flush mid-divide pulses dv_abort.
REQ-003 Ports: clk input 1, sole clock, rising edge; reset input 1, asynchronous active-high.
REQ-004 Ports: req_valid in 1, request present; req_ready out 1, accept; req_op in 2, 0=DIV 1=DIVU 2=REM 3=REMU; req_word in 1, 32-bit W variant; req_a/req_b in XLEN, dividend/divisor.
REQ-005 Ports: flush in 1, kill in-flight op; busy out 1, pipeline stall.
REQ-006 Ports: dv_start out 1, one-cycle start pulse; dv_abort out 1; dv_a/dv_b out XLEN, unsigned magnitudes; dv_done in 1, divider finished; dv_quot/dv_rem in XLEN, unsigned results.
REQ-007 Ports: resp_valid out 1; resp_ready in 1; resp_data out XLEN, final rd value.

Function
REQ-008 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-009 req_ready SHALL be 1 only in IDLE with flush=0; accept = req_valid&&req_ready.
REQ-010 On accept, SHALL register op, word, sign flags, magnitudes and special-case result.
REQ-011 Word ops: operands SHALL be low 32 bits, sign- (DIV/REM) or zero- (DIVU/REMU) extended before magnitude computation.
REQ-012 Signed ops: magnitude = two's-complement absolute value; neg_q = sign(a) XOR sign(b); neg_r = sign(a).
REQ-013 Divide-by-zero (effective b==0): SHALL go IDLE->RESP, no dv_start; quotient all ones, remainder = effective dividend.
REQ-014 Signed overflow (a = most negative of effective width, b = -1): IDLE->RESP, no dv_start; quotient = a, remainder = 0.
REQ-015 Otherwise IDLE->ISSUE; in ISSUE dv_start=1 for exactly one cycle with stable dv_a/dv_b, then ->WAIT.
REQ-016 dv_a/dv_b SHALL hold stable from ISSUE until leaving WAIT.
REQ-017 WAIT->RESP on dv_done; result latched that edge: select quot/rem, negate if neg flag, word ops sign-extend bit 31 to XLEN.
REQ-018 RESP: resp_valid=1, resp_data stable until resp_ready; on handshake ->IDLE; no new accept same cycle.
REQ-019 busy SHALL be 1 in ISSUE, WAIT, and RESP while resp_ready=0.
REQ-020 flush SHALL win over every other event: next state IDLE, no resp_valid; in ISSUE/WAIT with DIV_ABORT_EN=1, dv_abort=1 that cycle.
REQ-021 dv_done outside WAIT SHALL be ignored.
REQ-022 Latency: accept at T -> dv_start at T+1; special cases resp_valid at T+1; dv_done at D -> resp_valid at D+1.

Reset
REQ-023 reset SHALL force IDLE immediately; resp_valid, dv_start, dv_abort, busy = 0; resp_data, dv_a, dv_b = 0.
REQ-024 Reset mid-divide SHALL NOT pulse dv_abort; divider resets via the same reset.

Structure
REQ-025 Op encoding, state enum and XLEN constant SHALL live in the shared common package.
REQ-026 Sub-module div_operand_prep (combinational: extension, magnitude, sign flags, special-case detection) SHALL be instantiated once.

Verification
REQ-027 DIV a=-7 b=2 -> dv_a=7 dv_b=2; divider returns 3/1; resp_data=0xFFFF_FFFF_FFFF_FFFD; REM same operands -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-028 DIVU a=5 b=0 -> no dv_start, resp_valid at T+1, resp_data=0xFFFF_FFFF_FFFF_FFFF; REMU -> 5.
REQ-029 DIVW a=0x8000_0000 b=0xFFFF_FFFF -> no dv_start, resp_data=0xFFFF_FFFF_8000_0000; REMW -> 0.
REQ-030 REMUW a=0x1_0000_0005 b=3 -> dv_a=5 dv_b=3, resp_data=2.
REQ-031 resp_ready held 0 five cycles -> resp_valid, resp_data stable, busy=1, req_ready=0 throughout.
REQ-032 flush in WAIT -> dv_abort one cycle, IDLE next edge, late dv_done ignored, no resp_valid, next request accepted.

Source files
------------

// File: rtl/div_issue_pkg.sv
// rtl/div_issue_pkg.sv - shared constants and enums for the divide issue block
//
// Purpose : op encoding, FSM state enum and default datapath width shared by
//           div_issue and div_operand_prep.
// Ports   : none (package)
package div_issue_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_operand_prep.sv
// rtl/div_operand_prep.sv - operand extension, magnitudes, sign flags, special cases
//
// Purpose : purely combinational front end of the divide issue block.
// Ports   : i_op/i_word        operation and 32-bit W variant
//           i_a/i_b            raw dividend/divisor
//           o_mag_a/o_mag_b    unsigned magnitudes sent to the divider
//           o_neg_q/o_neg_r    negate quotient/remainder on return
//           o_special          divide-by-zero or signed overflow
//           o_special_result   final rd value for a special case
import div_issue_pkg::*;

module div_operand_prep #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [1:0]      i_op,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_mag_a,
  output logic [XLEN-1:0] o_mag_b,
  output logic            o_neg_q,
  output logic            o_neg_r,
  output logic            o_special,
  output logic [XLEN-1:0] o_special_result
);

  logic            w_signed;
  logic            w_is_rem;
  logic [XLEN-1:0] w_ea;
  logic [XLEN-1:0] w_eb;
  logic [XLEN-1:0] w_min;
  logic [XLEN-1:0] w_res;
  logic            w_sa;
  logic            w_sb;
  logic            w_div0;
  logic            w_ovf;

  always_comb begin
    w_signed = (i_op == OP_DIV) || (i_op == OP_REM);
    w_is_rem = i_op[1];
    if (i_word) begin
      w_ea  = {{(XLEN-32){w_signed & i_a[31]}}, i_a[31:0]};
      w_eb  = {{(XLEN-32){w_signed & i_b[31]}}, i_b[31:0]};
      // most negative 32-bit value, already sign-extended
      w_min = {{(XLEN-31){1'b1}}, 31'd0};
    end else begin
      w_ea  = i_a;
      w_eb  = i_b;
      w_min = {1'b1, {(XLEN-1){1'b0}}};
    end

    w_sa    = w_signed & w_ea[XLEN-1];
    w_sb    = w_signed & w_eb[XLEN-1];
    o_mag_a = w_sa ? -w_ea : w_ea;
    o_mag_b = w_sb ? -w_eb : w_eb;
    o_neg_q = w_sa ^ w_sb;
    o_neg_r = w_sa;

    w_div0 = (w_eb == '0);
    w_ovf  = w_signed && (w_ea == w_min) && (w_eb == '1);

    // divide-by-zero takes priority; overflow needs b = -1, so they never overlap
    if (w_div0) begin
      w_res = w_is_rem ? w_ea : '1;
    end else begin
      w_res = w_is_rem ? '0 : w_ea;
    end

    o_special        = w_div0 | w_ovf;
    o_special_result = i_word ? {{(XLEN-32){w_res[31]}}, w_res[31:0]} : w_res;
  end

endmodule

// File: rtl/div_issue.sv
// rtl/div_issue.sv - issues DIV/REM ops to an unsigned iterative divider
//
// Purpose : accepts a divide request, resolves special cases locally, otherwise
//           starts the divider with magnitudes and fixes up signs on return.
// Ports   : clk, reset (async, active-high)
//           req_valid/req_ready/req_op/req_word/req_a/req_b  request side
//           flush, busy                                      pipeline control
//           dv_start/dv_abort/dv_a/dv_b/dv_done/dv_quot/dv_rem divider side
//           resp_valid/resp_ready/resp_data                  result side
import div_issue_pkg::*;

module div_issue #(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter bit DIV_ABORT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            busy,
  output logic            dv_start,
  output logic            dv_abort,
  output logic [XLEN-1:0] dv_a,
  output logic [XLEN-1:0] dv_b,
  input  logic            dv_done,
  input  logic [XLEN-1:0] dv_quot,
  input  logic [XLEN-1:0] dv_rem,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data
);

  div_state_e      r_state;
  div_state_e      w_state_nxt;
  logic            r_is_rem;
  logic            r_word;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_dv_a;
  logic [XLEN-1:0] r_dv_b;
  logic [XLEN-1:0] r_resp_data;

  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_neg_q;
  logic            w_neg_r;
  logic            w_special;
  logic [XLEN-1:0] w_special_result;
  logic            w_accept;
  logic            w_done_take;
  logic [XLEN-1:0] w_sel;
  logic [XLEN-1:0] w_signed_res;
  logic [XLEN-1:0] w_result;

  div_operand_prep #(.XLEN(XLEN)) u_prep (
    .i_op             (req_op),
    .i_word           (req_word),
    .i_a              (req_a),
    .i_b              (req_b),
    .o_mag_a          (w_mag_a),
    .o_mag_b          (w_mag_b),
    .o_neg_q          (w_neg_q),
    .o_neg_r          (w_neg_r),
    .o_special        (w_special),
    .o_special_result (w_special_result)
  );

  assign w_accept    = req_valid && req_ready;
  assign w_done_take = (r_state == ST_WAIT) && dv_done && !flush;

  always_comb begin
    w_sel        = r_is_rem ? dv_rem : dv_quot;
    w_signed_res = (r_is_rem ? r_neg_r : r_neg_q) ? -w_sel : w_sel;
    w_result     = r_word ? {{(XLEN-32){w_signed_res[31]}}, w_signed_res[31:0]}
                          : w_signed_res;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    busy        = 1'b0;
    dv_start    = 1'b0;
    dv_abort    = 1'b0;
    resp_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = !flush;
        if (req_valid && !flush) begin
          w_state_nxt = w_special ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        busy        = 1'b1;
        dv_start    = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (dv_done) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        busy       = !resp_ready;
        if (resp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // flush overrides everything; a start in the same cycle is suppressed
    if (flush) begin
      w_state_nxt = ST_IDLE;
      resp_valid  = 1'b0;
      dv_start    = 1'b0;
      dv_abort    = DIV_ABORT_EN && ((r_state == ST_ISSUE) || (r_state == ST_WAIT));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_rem    <= 1'b0;
      r_word      <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dv_a      <= '0;
      r_dv_b      <= '0;
      r_resp_data <= '0;
    end else begin
      if (w_accept) begin
        r_is_rem <= req_op[1];
        r_word   <= req_word;
        r_neg_q  <= w_neg_q;
        r_neg_r  <= w_neg_r;
        r_dv_a   <= w_mag_a;
        r_dv_b   <= w_mag_b;
        if (w_special) begin
          r_resp_data <= w_special_result;
        end
      end
      if (w_done_take) begin
        r_resp_data <= w_result;
      end
    end
  end

  assign dv_a      = r_dv_a;
  assign dv_b      = r_dv_b;
  assign resp_data = r_resp_data;

endmodule
